// File: rtl/jk_counter_bank.sv
// Bank of JK flip-flop stages that can count up, count down, load in parallel, or take direct per-stage J/K control.
// Build with JKCNT_SATURATE_EN defined to make the counts stop at their end values instead of wrapping.
module jk_cell (
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q
);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) q <= 1'b0;
      else begin
         case ({j, k})
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            2'b11:   q <= ~q;
            default: q <= q;
         endcase
      end
   end
endmodule

module jk_counter_bank #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic             tc,
   output logic             wrap
);
   localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] target, jv, kv;
   logic             at_top, at_zero, wrap_nxt;

   assign at_top  = (q >= TOP);
   assign at_zero = (q == '0);

   // In the count modes, any stage whose next value differs from its current value is toggled.
   always_comb begin
      target   = q;
      jv       = '0;
      kv       = '0;
      wrap_nxt = 1'b0;
      if (en) begin
         if (load) begin
            jv = d;
            kv = ~d;
         end else begin
            case (mode)
               2'b01: begin
`ifdef JKCNT_SATURATE_EN
                  target = at_top ? TOP : q + WIDTH'(1);
`else
                  if (at_top) begin
                     target   = '0;
                     wrap_nxt = 1'b1;
                  end else target = q + WIDTH'(1);
`endif
                  jv = target ^ q;
                  kv = target ^ q;
               end
               2'b10: begin
`ifdef JKCNT_SATURATE_EN
                  target = at_zero ? '0 : q - WIDTH'(1);
`else
                  if (at_zero) begin
                     target   = TOP;
                     wrap_nxt = 1'b1;
                  end else target = q - WIDTH'(1);
`endif
                  jv = target ^ q;
                  kv = target ^ q;
               end
               2'b11: begin
                  jv = j;
                  kv = k;
               end
               default: ;
            endcase
         end
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : gen_stage
      jk_cell u_cell (
         .clk (clk),
         .rst (rst),
         .j   (jv[i]),
         .k   (kv[i]),
         .q   (q[i])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) wrap <= 1'b0;
      else      wrap <= wrap_nxt;
   end

   assign qbar = ~q;
   assign tc   = en & ~load & (((mode == 2'b01) & at_top) | ((mode == 2'b10) & at_zero));
endmodule

// File: tb/tb_jk_counter_bank.sv
// Directed test bench for jk_counter_bank (WIDTH=4, MODULUS=10), checked against a behavioural model.
module tb_jk_counter_bank;
   localparam int W = 4;
   localparam int M = 10;

   logic         clk = 0, rst = 1, en = 0, load = 0;
   logic [1:0]   mode = 0;
   logic [W-1:0] d = 0, j = 0, k = 0;
   logic [W-1:0] q, qbar;
   logic         tc, wrap;

   int errs = 0, checks = 0;
   int m_q = 0;
   bit m_w = 0;

   jk_counter_bank #(.WIDTH(W), .MODULUS(M)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
      .d(d), .j(j), .k(k), .q(q), .qbar(qbar), .tc(tc), .wrap(wrap)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: integer arithmetic on the count value, with each bit handled separately in JK mode
   always @(posedge clk or negedge rst) begin
      int nq;
      bit nw;
      bit v;
      nq = m_q;
      nw = 0;
      if (!rst) nq = 0;
      else if (en) begin
         if (load) nq = d;
         else begin
            case (mode)
               2'd1: begin
`ifdef JKCNT_SATURATE_EN
                  nq = (m_q >= M - 1) ? M - 1 : m_q + 1;
`else
                  if (m_q >= M - 1) begin nq = 0; nw = 1; end
                  else nq = m_q + 1;
`endif
               end
               2'd2: begin
`ifdef JKCNT_SATURATE_EN
                  nq = (m_q == 0) ? 0 : m_q - 1;
`else
                  if (m_q == 0) begin nq = M - 1; nw = 1; end
                  else nq = m_q - 1;
`endif
               end
               2'd3: begin
                  for (int b = 0; b < W; b++) begin
                     v = (m_q >> b) & 1;
                     if (j[b] && k[b]) v = !v;
                     else if (j[b])    v = 1;
                     else if (k[b])    v = 0;
                     nq = (nq & ~(1 << b)) | (int'(v) << b);
                  end
               end
               default: ;
            endcase
         end
      end
      m_q <= nq;
      m_w <= nw;
   end

   always @(negedge clk) begin
      bit etc;
      etc = en && !load && ((mode == 2'd1 && m_q >= M - 1) || (mode == 2'd2 && m_q == 0));
      check("model_q", q, m_q);
      check("model_qbar", qbar, (~m_q) & 15);
      check("model_tc", tc, etc);
      check("model_wrap", wrap, m_w);
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   initial begin
      int seq29[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
      int seq30[7]  = '{4, 3, 2, 1, 0, 9, 8};
      int wraps;
      #1 rst = 0;
      #2;
      check("reset_q", q, 0);
      check("reset_qbar", qbar, 4'hF);
      check("reset_wrap", wrap, 0);
      #10;
      rst = 1; en = 1; mode = 2'b01;

      // count up through the wrap
      for (int i = 0; i < 12; i++) begin
         tick();
         check("up_q", q, seq29[i]);
         if (seq29[i] == 9) check("up_tc_at9", tc, 1);
         if (i == 9) check("up_wrap", wrap, 1);
      end

      // load 5 then count down through the wrap
      load = 1; d = 5;
      tick();
      check("load5_q", q, 5);
      load = 0; mode = 2'b10; wraps = 0;
      for (int i = 0; i < 7; i++) begin
         tick();
         check("down_q", q, seq30[i]);
         if (seq30[i] == 0) check("down_tc_at0", tc, 1);
         wraps += int'(wrap);
      end
      check("down_wrap_count", wraps, 1);

      // direct JK mode: set/clear/toggle/hold per stage, then toggle all
      load = 1; d = 0; mode = 2'b11;
      tick();
      load = 0; j = 4'b1010; k = 4'b0110;
      tick();
      check("jk_q1", q, 4'b1010);
      check("jk_wrap1", wrap, 0);
      j = 4'b1111; k = 4'b1111;
      tick();
      check("jk_q2", q, 4'b0101);
      check("jk_wrap2", wrap, 0);

      // out-of-range load value
      load = 1; d = 12; mode = 2'b01;
      tick();
      check("ovr_load_q", q, 12);
      load = 0;
      #1 check("ovr_tc", tc, 1);
      tick();
      check("ovr_up_q", q, 0);
      check("ovr_up_wrap", wrap, 1);
      load = 1; d = 12;
      tick();
      load = 0; mode = 2'b10;
      tick();
      check("ovr_down_q", q, 11);
      check("ovr_down_wrap", wrap, 0);

      // hold, then mode changes that take effect on the very next edge
      mode = 2'b00;
      tick();
      check("hold_q", q, 11);
      mode = 2'b01;
      tick();
      check("chg_up_q", q, 0);
      mode = 2'b10;
      tick();
      check("chg_down_q", q, 9);
      check("chg_down_wrap", wrap, 1);

      // asynchronous reset between edges
      load = 1; d = 7; mode = 2'b01;
      tick();
      load = 0;
      #1 rst = 0;
      #1;
      check("midrst_q", q, 0);
      check("midrst_qbar", qbar, 4'hF);
      check("midrst_wrap", wrap, 0);
      #1 rst = 1;
      tick();
      check("resume_q", q, 1);

      // disabled: load and JK are both ignored
      en = 0; load = 1; d = 3;
      tick();
      check("en0_load_q", q, 1);
      load = 0; mode = 2'b11; j = 4'hF; k = 4'hF;
      tick();
      check("en0_jk_q", q, 1);
      check("en0_tc", tc, 0);

`ifdef JKCNT_SATURATE_EN
      en = 1; load = 1; d = 8; mode = 2'b01;
      tick();
      load = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("sat_q", q, 9);
         check("sat_wrap", wrap, 0);
         check("sat_tc", tc, 1);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end
endmodule
